// File: rtl/tl_protocol_checker.sv
// ----------------------------------------------------------------------------
// tl_protocol_checker
//
// Passive TileLink A/D channel monitor. It watches both channels and never
// drives a handshake. A channel "fires" when valid and ready are both high.
// It checks:
//   - beat-to-beat consistency of opcode/param/size/source inside a burst
//   - A param legality on the first beat
//   - per-source request tracking (double allocation, response without a
//     request, wrong response opcode, illegal D opcodes)
// The first error is captured in err_o/err_code_o and held until reset.
//
// Optional feature macro: TL_CHECKER_PERM_EN
//   When defined, the D param of Grant/GrantData is checked (code 0x8), and a
//   Grant answering an AcquirePerm must carry toT (code 0x9).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   a_valid_i/a_ready_i     A handshake (observed only)
//   a_opcode_i, a_param_i   A message opcode and param
//   a_size_i, a_source_i    A log2(bytes) size and source id
//   d_valid_i/d_ready_i     D handshake (observed only)
//   d_opcode_i, d_param_i   D message opcode and param
//   d_size_i, d_source_i    D log2(bytes) size and source id
//   err_o                   sticky error flag
//   err_code_o              code of the first error seen
//   outstanding_o           number of open requests in the tracker
//
// Error codes (lowest wins when several occur in one cycle):
//   0x1 A burst field change   0x2 D burst field change   0x3 illegal A param
//   0x4 source already busy    0x5 D with no open request  0x6 wrong response
//   0x7 ReleaseAck/reserved D  0x8 bad Grant param         0x9 AcquirePerm
//                                                             not granted toT
//
// Handshake note: this block is a pure observer; a beat counts only in a
// cycle where the channel's valid and ready are both sampled high at clk_i.
// ----------------------------------------------------------------------------
module tl_protocol_checker #(
    parameter int SourceWidth = 4,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   a_valid_i,
    input  logic                   a_ready_i,
    input  logic [2:0]             a_opcode_i,
    input  logic [2:0]             a_param_i,
    input  logic [SizeWidth-1:0]   a_size_i,
    input  logic [SourceWidth-1:0] a_source_i,
    input  logic                   d_valid_i,
    input  logic                   d_ready_i,
    input  logic [2:0]             d_opcode_i,
    input  logic [2:0]             d_param_i,
    input  logic [SizeWidth-1:0]   d_size_i,
    input  logic [SourceWidth-1:0] d_source_i,
    output logic                   err_o,
    output logic [3:0]             err_code_o,
    output logic [SourceWidth:0]   outstanding_o
);

    localparam int Entries = 2 ** SourceWidth;
    localparam int BeatLg  = $clog2(DataWidth / 8);
    // Wide enough for beats-1 at the largest encodable size.
    localparam int CntW    = 2 ** SizeWidth;
    localparam int OutW    = SourceWidth + 1;

    // A opcodes
    localparam logic [2:0] A_PUT_FULL  = 3'd0;
    localparam logic [2:0] A_PUT_PART  = 3'd1;
    localparam logic [2:0] A_ARITH     = 3'd2;
    localparam logic [2:0] A_LOGIC     = 3'd3;
    localparam logic [2:0] A_GET       = 3'd4;
    localparam logic [2:0] A_INTENT    = 3'd5;
    localparam logic [2:0] A_ACQ_BLOCK = 3'd6;
    localparam logic [2:0] A_ACQ_PERM  = 3'd7;
    // D opcodes
    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;
    localparam logic [2:0] D_HINT_ACK  = 3'd2;
    localparam logic [2:0] D_RSVD3     = 3'd3;
    localparam logic [2:0] D_GRANT     = 3'd4;
    localparam logic [2:0] D_GRANT_DAT = 3'd5;
    localparam logic [2:0] D_REL_ACK   = 3'd6;
    localparam logic [2:0] D_RSVD7     = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } beat_state_e;

    // beats - 1 for a message; single-beat messages always give 0.
    function automatic logic [CntW-1:0] beats_m1(input logic [SizeWidth-1:0] size,
                                                 input logic                 multi);
        logic [CntW-1:0] r;
        r = '0;
        if (multi && (int'(size) > BeatLg)) begin
            r = (CntW'(1) << (int'(size) - BeatLg)) - CntW'(1);
        end
        return r;
    endfunction

    function automatic logic a_param_ok(input logic [2:0] op, input logic [2:0] par);
        logic ok;
        case (op)
            A_ARITH:                ok = (par <= 3'd4);
            A_LOGIC:                ok = (par <= 3'd3);
            A_ACQ_BLOCK, A_ACQ_PERM: ok = (par <= 3'd2);
            default:                ok = (par == 3'd0);
        endcase
        return ok;
    endfunction

    function automatic logic resp_ok(input logic [2:0] req, input logic [2:0] rsp);
        logic ok;
        case (req)
            A_PUT_FULL, A_PUT_PART:  ok = (rsp == D_ACK);
            A_GET, A_ARITH, A_LOGIC: ok = (rsp == D_ACK_DATA);
            A_INTENT:                ok = (rsp == D_HINT_ACK);
            A_ACQ_BLOCK:             ok = (rsp == D_GRANT) || (rsp == D_GRANT_DAT);
            default:                 ok = (rsp == D_GRANT);
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    beat_state_e            a_state_q, a_state_d;
    logic [CntW-1:0]        a_cnt_q, a_cnt_d;
    logic [2:0]             a_opcode_q, a_opcode_d;
    logic [2:0]             a_param_q, a_param_d;
    logic [SizeWidth-1:0]   a_size_q, a_size_d;
    logic [SourceWidth-1:0] a_source_q, a_source_d;

    beat_state_e            d_state_q, d_state_d;
    logic [CntW-1:0]        d_cnt_q, d_cnt_d;
    logic [2:0]             d_opcode_q, d_opcode_d;
    logic [2:0]             d_param_q, d_param_d;
    logic [SizeWidth-1:0]   d_size_q, d_size_d;
    logic [SourceWidth-1:0] d_source_q, d_source_d;

    logic [Entries-1:0]     entry_valid_q, entry_valid_d;
    logic [2:0]             entry_opcode_q [Entries];
    logic [2:0]             entry_opcode_d [Entries];

    logic                   err_q, err_d;
    logic [3:0]             err_code_q, err_code_d;
    logic [OutW-1:0]        outstanding_q, outstanding_d;

    // ------------------------------------------------------------------
    // Combinational checks
    // ------------------------------------------------------------------
    logic                   a_fire, a_first, a_multi, a_busy;
    logic                   d_fire, d_first, d_last, d_multi, d_bad_op;
    logic [CntW-1:0]        a_bm1, d_bm1;
    logic [SourceWidth-1:0] d_src_eff;
    logic                   d_entry_v;
    logic [2:0]             d_entry_op;
    logic                   alloc_inc, free_dec;
    logic [9:1]             err_flags;

    always_comb begin
        a_fire     = a_valid_i && a_ready_i;
        d_fire     = d_valid_i && d_ready_i;
        a_first    = a_fire && (a_state_q == IDLE);
        d_first    = d_fire && (d_state_q == IDLE);
        a_multi    = (a_opcode_i <= A_LOGIC);
        d_multi    = (d_opcode_i == D_ACK_DATA) || (d_opcode_i == D_GRANT_DAT);
        a_bm1      = beats_m1(a_size_i, a_multi);
        d_bm1      = beats_m1(d_size_i, d_multi);
        d_bad_op   = (d_opcode_i == D_RSVD3) || (d_opcode_i == D_REL_ACK) ||
                     (d_opcode_i == D_RSVD7);
        // Later beats of a D burst free the source latched on its first beat.
        d_src_eff  = (d_state_q == IDLE) ? d_source_i : d_source_q;
        d_last     = d_fire && (((d_state_q == IDLE) && (d_bm1 == '0)) ||
                                ((d_state_q == BURST) && (d_cnt_q == CntW'(1))));
        d_entry_v  = entry_valid_q[d_source_i];
        d_entry_op = entry_opcode_q[d_source_i];
        // A same-cycle D last beat frees the entry before A allocates it.
        a_busy     = entry_valid_q[a_source_i] && !(d_last && (d_src_eff == a_source_i));

        err_flags  = '0;

        // A beat counter and field latch
        a_state_d  = a_state_q;
        a_cnt_d    = a_cnt_q;
        a_opcode_d = a_opcode_q;
        a_param_d  = a_param_q;
        a_size_d   = a_size_q;
        a_source_d = a_source_q;
        if (a_fire) begin
            if (a_state_q == IDLE) begin
                a_opcode_d = a_opcode_i;
                a_param_d  = a_param_i;
                a_size_d   = a_size_i;
                a_source_d = a_source_i;
                if (a_bm1 != '0) begin
                    a_state_d = BURST;
                    a_cnt_d   = a_bm1;
                end
                if (!a_param_ok(a_opcode_i, a_param_i)) err_flags[3] = 1'b1;
                if (a_busy) err_flags[4] = 1'b1;
            end else begin
                if ((a_opcode_i != a_opcode_q) || (a_param_i != a_param_q) ||
                    (a_size_i != a_size_q) || (a_source_i != a_source_q)) begin
                    err_flags[1] = 1'b1;
                end
                a_cnt_d = a_cnt_q - CntW'(1);
                if (a_cnt_q == CntW'(1)) a_state_d = IDLE;
            end
        end

        // D beat counter and field latch
        d_state_d  = d_state_q;
        d_cnt_d    = d_cnt_q;
        d_opcode_d = d_opcode_q;
        d_param_d  = d_param_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        if (d_fire) begin
            if (d_state_q == IDLE) begin
                d_opcode_d = d_opcode_i;
                d_param_d  = d_param_i;
                d_size_d   = d_size_i;
                d_source_d = d_source_i;
                if (d_bm1 != '0) begin
                    d_state_d = BURST;
                    d_cnt_d   = d_bm1;
                end
            end else begin
                if ((d_opcode_i != d_opcode_q) || (d_param_i != d_param_q) ||
                    (d_size_i != d_size_q) || (d_source_i != d_source_q)) begin
                    err_flags[2] = 1'b1;
                end
                d_cnt_d = d_cnt_q - CntW'(1);
                if (d_cnt_q == CntW'(1)) d_state_d = IDLE;
            end
        end

        // D first-beat response checks against the tracker
        if (d_first) begin
            if (d_bad_op) err_flags[7] = 1'b1;
            if (!d_entry_v) begin
                err_flags[5] = 1'b1;
            end else if (!d_bad_op && !resp_ok(d_entry_op, d_opcode_i)) begin
                err_flags[6] = 1'b1;
            end
`ifdef TL_CHECKER_PERM_EN
            if ((d_opcode_i == D_GRANT) || (d_opcode_i == D_GRANT_DAT)) begin
                // Cap params: toT=0, toB=1, toN=2
                if (d_param_i > 3'd2) err_flags[8] = 1'b1;
                if ((d_opcode_i == D_GRANT) && d_entry_v && (d_entry_op == A_ACQ_PERM) &&
                    (d_param_i != 3'd0)) begin
                    err_flags[9] = 1'b1;
                end
            end
`endif
        end

        // Tracker: free first, then allocate
        entry_valid_d  = entry_valid_q;
        entry_opcode_d = entry_opcode_q;
        free_dec       = d_last && entry_valid_q[d_src_eff];
        alloc_inc      = a_first && !a_busy;
        if (d_last) entry_valid_d[d_src_eff] = 1'b0;
        if (a_first) begin
            entry_valid_d[a_source_i]  = 1'b1;
            entry_opcode_d[a_source_i] = a_opcode_i;
        end

        outstanding_d = outstanding_q;
        if (alloc_inc && !free_dec && (outstanding_q != OutW'(Entries))) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (free_dec && !alloc_inc && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OutW'(1);
        end

        // First error only; scanning downward leaves the lowest code.
        err_d      = err_q;
        err_code_d = err_code_q;
        if (!err_q && (err_flags != '0)) begin
            err_d = 1'b1;
            for (int i = 9; i >= 1; i--) begin
                if (err_flags[i]) err_code_d = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_state_q      <= IDLE;
            a_cnt_q        <= '0;
            a_opcode_q     <= '0;
            a_param_q      <= '0;
            a_size_q       <= '0;
            a_source_q     <= '0;
            d_state_q      <= IDLE;
            d_cnt_q        <= '0;
            d_opcode_q     <= '0;
            d_param_q      <= '0;
            d_size_q       <= '0;
            d_source_q     <= '0;
            entry_valid_q  <= '0;
            entry_opcode_q <= '{default: '0};
            err_q          <= 1'b0;
            err_code_q     <= 4'h0;
            outstanding_q  <= '0;
        end else begin
            a_state_q      <= a_state_d;
            a_cnt_q        <= a_cnt_d;
            a_opcode_q     <= a_opcode_d;
            a_param_q      <= a_param_d;
            a_size_q       <= a_size_d;
            a_source_q     <= a_source_d;
            d_state_q      <= d_state_d;
            d_cnt_q        <= d_cnt_d;
            d_opcode_q     <= d_opcode_d;
            d_param_q      <= d_param_d;
            d_size_q       <= d_size_d;
            d_source_q     <= d_source_d;
            entry_valid_q  <= entry_valid_d;
            entry_opcode_q <= entry_opcode_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            outstanding_q  <= outstanding_d;
        end
    end

    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_tl_protocol_checker.sv
// ----------------------------------------------------------------------------
// tb_tl_protocol_checker
//
// Directed bench for tl_protocol_checker (SourceWidth 4, DataWidth 64,
// SizeWidth 3). Each step drives one cycle of A/D traffic, pushes the
// expected {err_o, err_code_o, outstanding_o} for the following cycle onto a
// queue, then pops and compares it against the DUT after the clock edge.
// Build with +define+TL_CHECKER_PERM_EN to exercise the Grant param checks.
// ----------------------------------------------------------------------------
module tb_tl_protocol_checker;

    localparam int SW = 4;
    localparam int DW = 64;
    localparam int ZW = 3;
    localparam int EW = 1 + 4 + SW + 1;

    localparam logic [2:0] A_PUT_FULL  = 3'd0;
    localparam logic [2:0] A_ARITH     = 3'd2;
    localparam logic [2:0] A_GET       = 3'd4;
    localparam logic [2:0] A_ACQ_BLOCK = 3'd6;
    localparam logic [2:0] A_ACQ_PERM  = 3'd7;
    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;
    localparam logic [2:0] D_RSVD3     = 3'd3;
    localparam logic [2:0] D_GRANT     = 3'd4;
    localparam logic [2:0] D_GRANT_DAT = 3'd5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    always #5 clk = ~clk;

    logic          a_valid, a_ready, d_valid, d_ready;
    logic [2:0]    a_opcode, a_param, d_opcode, d_param;
    logic [ZW-1:0] a_size, d_size;
    logic [SW-1:0] a_source, d_source;
    logic          err_o;
    logic [3:0]    err_code_o;
    logic [SW:0]   outstanding_o;

    tl_protocol_checker #(
        .SourceWidth (SW),
        .DataWidth   (DW),
        .SizeWidth   (ZW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .a_valid_i     (a_valid),
        .a_ready_i     (a_ready),
        .a_opcode_i    (a_opcode),
        .a_param_i     (a_param),
        .a_size_i      (a_size),
        .a_source_i    (a_source),
        .d_valid_i     (d_valid),
        .d_ready_i     (d_ready),
        .d_opcode_i    (d_opcode),
        .d_param_i     (d_param),
        .d_size_i      (d_size),
        .d_source_i    (d_source),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .outstanding_o (outstanding_o)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic compare(input string tag);
        logic [EW-1:0] exp_v;
        logic [EW-1:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {err_o, err_code_o, outstanding_o};
        n_assert++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed err=%0b code=%0h out=%0d, expected err=%0b code=%0h out=%0d",
                   tag, obs_v[EW-1], obs_v[EW-2 -: 4], obs_v[SW:0],
                   exp_v[EW-1], exp_v[EW-2 -: 4], exp_v[SW:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_a(input logic [2:0] op, input logic [2:0] par,
                         input logic [ZW-1:0] sz, input logic [SW-1:0] src);
        a_valid  = 1'b1;
        a_opcode = op;
        a_param  = par;
        a_size   = sz;
        a_source = src;
    endtask

    task automatic set_d(input logic [2:0] op, input logic [2:0] par,
                         input logic [ZW-1:0] sz, input logic [SW-1:0] src);
        d_valid  = 1'b1;
        d_opcode = op;
        d_param  = par;
        d_size   = sz;
        d_source = src;
    endtask

    // Runs one cycle of whatever is set up, then checks the registered result.
    task automatic tick(input string tag, input logic e, input logic [3:0] c,
                        input logic [SW:0] o);
        exp_q.push_back({e, c, o});
        @(posedge clk);
        #1;
        compare(tag);
        @(negedge clk);
        a_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    // Asynchronous reset; outputs are checked while rst is high, before any edge.
    task automatic do_reset(input string tag);
        a_valid = 1'b0;
        d_valid = 1'b0;
        rst     = 1'b1;
        exp_q.push_back('0);
        #2;
        compare(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [SW-1:0] rsrc;
    logic          exp_perm_err;
    logic [3:0]    exp_perm_code;

    initial begin
        a_valid = 1'b0; a_ready = 1'b1; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        d_valid = 1'b0; d_ready = 1'b1; d_opcode = '0; d_param = '0; d_size = '0; d_source = '0;
        @(negedge clk);
        // Put outputs in a non-reset state first so the reset check means something.
        set_a(A_GET, 3'd0, 3'd3, 4'd3);
        tick("pre_reset_alloc", 1'b0, 4'h0, 5'd1);
        do_reset("reset_state");

        // One-beat Get/AccessAckData on source 3: outstanding 0 -> 1 -> 0
        set_a(A_GET, 3'd0, 3'd3, 4'd3);
        tick("get_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd3, 4'd3);
        tick("get_free", 1'b0, 4'h0, 5'd0);

        // valid without ready is not a fire
        a_ready = 1'b0;
        set_a(A_GET, 3'd0, 3'd3, 4'd5);
        tick("no_fire", 1'b0, 4'h0, 5'd0);
        a_ready = 1'b1;

        // 4-beat PutFullData (size 5), single AccessAck
        for (int i = 0; i < 4; i++) begin
            set_a(A_PUT_FULL, 3'd0, 3'd5, 4'd1);
            tick("put_beat", 1'b0, 4'h0, 5'd1);
        end
        set_d(D_ACK, 3'd0, 3'd5, 4'd1);
        tick("put_ack", 1'b0, 4'h0, 5'd0);

        // AcquireBlock answered by an 8-beat GrantData on a random high source
        rsrc = 4'($urandom_range(8, 15));
        set_a(A_ACQ_BLOCK, 3'd0, 3'd6, rsrc);
        tick("acq_alloc", 1'b0, 4'h0, 5'd1);
        for (int i = 0; i < 8; i++) begin
            set_d(D_GRANT_DAT, 3'd0, 3'd6, rsrc);
            tick("grantdata_beat", 1'b0, 4'h0, (i == 7) ? 5'd0 : 5'd1);
        end

        // Same-cycle free and re-allocate on source 1
        set_a(A_GET, 3'd0, 3'd3, 4'd1);
        tick("sc_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd3, 4'd1);
        set_a(A_GET, 3'd0, 3'd3, 4'd1);
        tick("sc_free_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd3, 4'd1);
        tick("sc_final_free", 1'b0, 4'h0, 5'd0);

        // Reset mid-burst, then a fresh one-beat Get must be a first beat
        for (int i = 0; i < 2; i++) begin
            set_a(A_PUT_FULL, 3'd0, 3'd5, 4'd2);
            tick("burst_before_rst", 1'b0, 4'h0, 5'd1);
        end
        do_reset("reset_mid_burst");
        set_a(A_GET, 3'd0, 3'd3, 4'd0);
        tick("get_after_rst", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd3, 4'd0);
        tick("ack_after_rst", 1'b0, 4'h0, 5'd0);

        // A source changed on beat 3 -> 0x1, held through beat 4
        for (int i = 0; i < 2; i++) begin
            set_a(A_PUT_FULL, 3'd0, 3'd5, 4'd6);
            tick("a_burst_ok", 1'b0, 4'h0, 5'd1);
        end
        set_a(A_PUT_FULL, 3'd0, 3'd5, 4'd7);
        tick("a_burst_src_change", 1'b1, 4'h1, 5'd1);
        set_a(A_PUT_FULL, 3'd0, 3'd5, 4'd6);
        tick("a_burst_sticky", 1'b1, 4'h1, 5'd1);

        // Double Get on source 2 -> 0x4
        do_reset("reset_dup");
        set_a(A_GET, 3'd0, 3'd3, 4'd2);
        tick("dup_first", 1'b0, 4'h0, 5'd1);
        set_a(A_GET, 3'd0, 3'd3, 4'd2);
        tick("dup_second", 1'b1, 4'h4, 5'd1);

        // AccessAck on idle source 7 -> 0x5
        do_reset("reset_noreq");
        set_d(D_ACK, 3'd0, 3'd3, 4'd7);
        tick("d_no_request", 1'b1, 4'h5, 5'd0);

        // Get answered by AccessAck -> 0x6
        do_reset("reset_wrongresp");
        set_a(A_GET, 3'd0, 3'd3, 4'd9);
        tick("wr_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK, 3'd0, 3'd3, 4'd9);
        tick("wrong_response", 1'b1, 4'h6, 5'd0);

        // Reserved D opcode -> 0x7
        do_reset("reset_rsvd");
        set_a(A_GET, 3'd0, 3'd3, 4'd10);
        tick("rsvd_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_RSVD3, 3'd0, 3'd3, 4'd10);
        tick("reserved_d_opcode", 1'b1, 4'h7, 5'd0);

        // Bad param and busy source in one cycle -> lowest code 0x3; later error ignored
        do_reset("reset_multi");
        set_a(A_GET, 3'd0, 3'd3, 4'd0);
        tick("multi_alloc", 1'b0, 4'h0, 5'd1);
        set_a(A_ARITH, 3'd7, 3'd3, 4'd0);
        tick("param_and_busy", 1'b1, 4'h3, 5'd1);
        set_d(D_ACK, 3'd0, 3'd3, 4'd0);
        tick("first_error_held", 1'b1, 4'h3, 5'd0);

        // D param changed mid burst -> 0x2; burst still completes and frees
        do_reset("reset_dburst");
        set_a(A_GET, 3'd0, 3'd5, 4'd3);
        tick("dburst_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd5, 4'd3);
        tick("dburst_b1", 1'b0, 4'h0, 5'd1);
        set_d(D_ACK_DATA, 3'd1, 3'd5, 4'd3);
        tick("dburst_param_change", 1'b1, 4'h2, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd5, 4'd3);
        tick("dburst_b3", 1'b1, 4'h2, 5'd1);
        set_d(D_ACK_DATA, 3'd0, 3'd5, 4'd3);
        tick("dburst_last", 1'b1, 4'h2, 5'd0);

        // AcquirePerm NtoT answered by Grant toB
`ifdef TL_CHECKER_PERM_EN
        exp_perm_err  = 1'b1;
        exp_perm_code = 4'h9;
`else
        exp_perm_err  = 1'b0;
        exp_perm_code = 4'h0;
`endif
        do_reset("reset_perm");
        set_a(A_ACQ_PERM, 3'd1, 3'd6, 4'd5);
        tick("perm_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_GRANT, 3'd1, 3'd6, 4'd5);
        tick("perm_grant_tob", exp_perm_err, exp_perm_code, 5'd0);

        // Grant param out of range (toN+1)
`ifdef TL_CHECKER_PERM_EN
        exp_perm_code = 4'h8;
`endif
        do_reset("reset_gparam");
        set_a(A_ACQ_BLOCK, 3'd0, 3'd3, 4'd4);
        tick("gparam_alloc", 1'b0, 4'h0, 5'd1);
        set_d(D_GRANT, 3'd3, 3'd3, 4'd4);
        tick("grant_bad_param", exp_perm_err, exp_perm_code, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_protocol_checker.md
TL_PROTOCOL_CHECKER -- requirements
Module: tl_protocol_checker

Interface
REQ-001 SHALL have parameter SourceWidth, default 4, meaning width of A/D source field; tracker depth is 2^SourceWidth.
REQ-002 SHALL have parameter DataWidth, default 64, meaning beat width in bits; a power of two, at least 8.
REQ-003 SHALL have parameter SizeWidth, default 3, meaning width of the log2(bytes) size field.
REQ-004 SHALL have ports, one per line:
- clk_i, input, 1, sole clock.
- rst_i, input, 1, asynchronous active-high reset.
- a_valid_i / a_ready_i, input, 1 each, A handshake.
- a_opcode_i, input, 3, A opcode.
- a_param_i, input, 3, A param.
- a_size_i, input, SizeWidth, A size.
- a_source_i, input, SourceWidth, A source.
- d_valid_i / d_ready_i, input, 1 each, D handshake.
- d_opcode_i, input, 3, D opcode.
- d_param_i, input, 3, D param.
- d_size_i, input, SizeWidth, D size.
- d_source_i, input, SourceWidth, D source.
- err_o, output, 1, sticky error flag.
- err_code_o, output, 4, code of first error.
- outstanding_o, output, SourceWidth+1, count of open requests.

Function
REQ-005 SHALL be a passive monitor: it drives no handshake signals, and a channel fires only when valid and ready are both high.
REQ-006 SHALL compute beats as max(1, 2^size / (DataWidth/8)).
- A channel is multi-beat only for PutFullData, PutPartialData, ArithmeticData and LogicalData.
- D channel is multi-beat only for AccessAckData and GrantData.
- All other messages are one beat.
REQ-007 SHALL run a per-channel beat counter (states IDLE and BURST): the first fire loads beats-1, each later fire decrements, and reaching 0 returns to IDLE.
REQ-008 SHALL latch opcode, param, size and source on a first beat; any differing field on a later beat raises code 0x1 (A) or 0x2 (D).
REQ-009 SHALL check A param on the first beat, raising 0x3 if illegal:
- Put/Get/Intent: param 0.
- ArithmeticData: 0..4.
- LogicalData: 0..3.
- AcquireBlock/AcquirePerm: NtoB, NtoT or BtoT (0..2).
REQ-010 SHALL allocate tracker entry[source] (valid, opcode) on an A first-beat fire; if the entry is already valid, SHALL raise 0x4.
REQ-011 SHALL check each D first beat against entry[source]:
- Entry invalid: raise 0x5.
- Opcode mismatch: raise 0x6. Expected responses: Put -> AccessAck; Get/Arithmetic/Logical -> AccessAckData; Intent -> HintAck; AcquireBlock -> Grant or GrantData; AcquirePerm -> Grant.
- ReleaseAck or a reserved D opcode (3, 7): raise 0x7.
REQ-012 SHALL free entry[source] on the D last-beat fire.
REQ-013 SHALL, when a D last beat and an A first beat for the same source fire in the same cycle, process the free first, so the A allocation is legal.
REQ-014 SHALL keep outstanding_o equal to the number of valid entries; simultaneous allocate and free leave it unchanged, and it never wraps (saturates at 0 and 2^SourceWidth).
REQ-015 SHALL register err_o and err_code_o; both update the cycle after the offending fire.
REQ-016 SHALL capture only the first error: err_code_o holds until reset, and err_o is sticky.
REQ-017 SHALL resolve multiple errors in one cycle by reporting the lowest code.

Reset
REQ-018 SHALL, on rst_i, asynchronously clear all tracker entries, both beat counters (to IDLE), err_o, err_code_o (0x0) and outstanding_o (0).
REQ-019 SHALL discard any burst in flight when reset is asserted mid-burst; the first fire after release is treated as a first beat.

Configuration
REQ-020 SHALL support macro TL_CHECKER_PERM_EN.
- Defined: checks D param on Grant/GrantData (must be toT, toB or toN; raise 0x8). Also requires a Grant answering AcquirePerm to carry toT (raise 0x9).
- Undefined: no D param checks; codes 0x8/0x9 never raised.

Verification
REQ-021 SHALL cover: Get, source 3, size 3 -> one-beat AccessAckData, source 3 -> err_o stays 0, and outstanding_o goes 0,1,0.
REQ-022 SHALL cover: PutFullData, size 5, DataWidth 64 (4 beats), with a_source changed on beat 3 -> err_o=1, err_code_o=0x1 on the next cycle.
REQ-023 SHALL cover: two A Gets on source 2 with no D between -> err_code_o=0x4; a D AccessAck on idle source 7 (fresh reset) -> err_code_o=0x5.
REQ-024 SHALL cover: AcquirePerm with param NtoT answered by Grant param toB -> err_code_o=0x9 with TL_CHECKER_PERM_EN, err_o=0 without.
REQ-025 SHALL cover: D last beat and A first beat on source 1 in the same cycle -> no error, outstanding_o unchanged; rst_i asserted mid 4-beat burst, then a fresh one-beat Get -> no error.
